// File: rtl/dmem_copy_engine_if.sv
// Data-memory request/response bundle shared by a requester (master) and the memory (slave).
interface dmem_copy_engine_if;
    logic [31:0] addr;
    logic [31:0] write_data;
    logic        memread;
    logic        memwrite;
    logic [3:0]  sign_mask;
    logic [31:0] read_data;
    logic        clk_stall;

    modport master (
        output addr, write_data, memread, memwrite, sign_mask,
        input  read_data, clk_stall
    );

    modport slave (
        input  addr, write_data, memread, memwrite, sign_mask,
        output read_data, clk_stall
    );
endinterface

// File: rtl/dmem_copy_engine.sv
// Word-granular memory-to-memory copy initiator: one read then one write per word,
// ascending addresses, registered single-cycle requests on the data-memory port.
module dmem_copy_engine #(
    parameter int         LEN_W          = 10,
    parameter logic [3:0] WORD_SIGN_MASK = 4'b0100
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [31:0]       src_addr,
    input  logic [31:0]       dst_addr,
    input  logic [LEN_W-1:0]  len,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [LEN_W-1:0]  words_done,
    dmem_copy_engine_if.master mem
);

    typedef enum logic [2:0] {
        IDLE, RD_REQ, RD_WAIT, WR_REQ, WR_WAIT, FINISH
    } state_e;

    state_e           state_q, state_d;
    logic [31:0]      src_q, src_d;
    logic [31:0]      dst_q, dst_d;
    logic [31:0]      addr_q, addr_d;
    logic [31:0]      wdata_q, wdata_d;
    logic [LEN_W-1:0] len_q, len_d;
    logic [LEN_W-1:0] words_q, words_d;
    logic             first_q, first_d;
    logic             rd_q, rd_d;
    logic             wr_q, wr_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             err_q, err_d;
    logic             misaligned;
    logic             stalled;

    assign misaligned = (src_addr[1:0] != 2'b00) || (dst_addr[1:0] != 2'b00);
    // The memory never answers in the cycle right after a request, so that cycle always waits.
    assign stalled    = first_q || mem.clk_stall;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            src_q   <= '0;
            dst_q   <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            len_q   <= '0;
            words_q <= '0;
            first_q <= 1'b0;
            rd_q    <= 1'b0;
            wr_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            src_q   <= src_d;
            dst_q   <= dst_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            len_q   <= len_d;
            words_q <= words_d;
            first_q <= first_d;
            rd_q    <= rd_d;
            wr_q    <= wr_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        src_d   = src_q;
        dst_d   = dst_q;
        len_d   = len_q;
        words_d = words_q;
        wdata_d = wdata_q;
        first_d = (state_q == RD_REQ) || (state_q == WR_REQ);
        case (state_q)
            IDLE: begin
                if (start && !misaligned) begin
                    words_d = '0;
                    if (len == '0) begin
                        state_d = FINISH;
                    end else begin
                        src_d   = src_addr;
                        dst_d   = dst_addr;
                        len_d   = len;
                        state_d = RD_REQ;
                    end
                end
            end
            RD_REQ:  state_d = RD_WAIT;
            RD_WAIT: begin
                if (!stalled) begin
                    wdata_d = mem.read_data;
                    state_d = WR_REQ;
                end
            end
            WR_REQ:  state_d = WR_WAIT;
            WR_WAIT: begin
                if (!stalled) begin
                    words_d = words_q + LEN_W'(1);
                    src_d   = src_q + 32'd4;
                    dst_d   = dst_q + 32'd4;
                    state_d = (words_q + LEN_W'(1) < len_q) ? RD_REQ : FINISH;
                end
            end
            FINISH:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Outputs are decoded from the next state so every port comes straight from a flop.
    always_comb begin
        rd_d   = (state_d == RD_REQ);
        wr_d   = (state_d == WR_REQ);
        busy_d = (state_d == RD_REQ) || (state_d == RD_WAIT) ||
                 (state_d == WR_REQ) || (state_d == WR_WAIT);
        done_d = (state_d == FINISH);
        err_d  = (state_q == IDLE) && start && misaligned;
        addr_d = addr_q;
        if (rd_d) begin
            addr_d = src_d;
        end else if (wr_d) begin
            addr_d = dst_d;
        end
    end

    assign busy           = busy_q;
    assign done           = done_q;
    assign err            = err_q;
    assign words_done     = words_q;
    assign mem.addr       = addr_q;
    assign mem.write_data = wdata_q;
    assign mem.memread    = rd_q;
    assign mem.memwrite   = wr_q;
    assign mem.sign_mask  = WORD_SIGN_MASK;

endmodule

// File: tb/tb_dmem_copy_engine.sv
// Testbench for dmem_copy_engine: a word-addressed memory model with random stalls and a
// sequential copy reference model that predicts memory contents and request timing.
module tb_dmem_copy_engine;
    localparam int LEN_W     = 10;
    localparam int MEM_WORDS = 4096;
    localparam int MAX_CYC   = 512;

    logic             clk = 1'b0;
    logic             reset;
    logic             start;
    logic [31:0]      src_addr;
    logic [31:0]      dst_addr;
    logic [LEN_W-1:0] len;
    logic             busy;
    logic             done;
    logic             err;
    logic [LEN_W-1:0] words_done;

    dmem_copy_engine_if memBus();

    dmem_copy_engine #(.LEN_W(LEN_W), .WORD_SIGN_MASK(4'b0100)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .src_addr   (src_addr),
        .dst_addr   (dst_addr),
        .len        (len),
        .busy       (busy),
        .done       (done),
        .err        (err),
        .words_done (words_done),
        .mem        (memBus)
    );

    always #5 clk = ~clk;

    logic [31:0] memArr [MEM_WORDS];
    logic [31:0] refMem [MEM_WORDS];
    logic [31:0] rdataReg;
    int          stallCnt;
    int          stallMax;
    logic        fillReq;
    logic        pokeEn;
    logic [31:0] pokeAddr;
    logic [31:0] pokeData;

    int vecCount;
    int failCount;

    logic        rdA   [MAX_CYC];
    logic        wrA   [MAX_CYC];
    logic        busyA [MAX_CYC];
    logic        doneA [MAX_CYC];
    logic        errA  [MAX_CYC];
    logic [31:0] addrA [MAX_CYC];
    logic [31:0] dataA [MAX_CYC];
    logic [31:0] expData [$];

    function automatic int widx(input logic [31:0] a);
        return int'(a[13:2]);
    endfunction

    // Memory answers each request after a random number of stall cycles.
    always @(posedge clk) begin
        if (fillReq) begin
            for (int i = 0; i < MEM_WORDS; i++) memArr[i] <= $urandom();
        end else if (pokeEn) begin
            memArr[widx(pokeAddr)] <= pokeData;
        end
        if (memBus.memwrite) memArr[widx(memBus.addr)] <= memBus.write_data;
        if (memBus.memread) rdataReg <= memArr[widx(memBus.addr)];
        if (memBus.memread || memBus.memwrite)
            stallCnt <= (stallMax == 0) ? 0 : int'($urandom_range(0, stallMax));
        else if (stallCnt != 0)
            stallCnt <= stallCnt - 1;
    end

    assign memBus.read_data = rdataReg;
    assign memBus.clk_stall = (stallCnt != 0);

    initial begin
        #1000000;
        $display("[TB] FAIL global_timeout got running want finished");
        $fatal(1, "[TB] simulation time limit exceeded");
    end

    task automatic pokeWord(input logic [31:0] a, input logic [31:0] d);
        @(negedge clk);
        pokeEn   = 1'b1;
        pokeAddr = a;
        pokeData = d;
        @(negedge clk);
        pokeEn   = 1'b0;
    endtask

    task automatic applyStimulus(input logic [31:0] src, input logic [31:0] dst,
                                 input logic [LEN_W-1:0] n);
        @(negedge clk);
        src_addr = src;
        dst_addr = dst;
        len      = n;
        start    = 1'b1;
    endtask

    task automatic sampleCycle(input int c);
        rdA[c]   = memBus.memread;
        wrA[c]   = memBus.memwrite;
        busyA[c] = busy;
        doneA[c] = done;
        errA[c]  = err;
        addrA[c] = memBus.addr;
        dataA[c] = memBus.write_data;
    endtask

    task automatic test_reset();
        fillReq = 1'b1;
        reset   = 1'b1;
        @(negedge clk);
        fillReq = 1'b0;
        repeat (2) @(negedge clk);
        vecCount += 9;
        if (busy !== 1'b0) begin $display("[TB] FAIL reset_busy got %b want 0", busy); failCount++; end
        if (done !== 1'b0) begin $display("[TB] FAIL reset_done got %b want 0", done); failCount++; end
        if (err !== 1'b0) begin $display("[TB] FAIL reset_err got %b want 0", err); failCount++; end
        if (memBus.memread !== 1'b0) begin $display("[TB] FAIL reset_memread got %b want 0", memBus.memread); failCount++; end
        if (memBus.memwrite !== 1'b0) begin $display("[TB] FAIL reset_memwrite got %b want 0", memBus.memwrite); failCount++; end
        if (words_done !== '0) begin $display("[TB] FAIL reset_words_done got %0d want 0", words_done); failCount++; end
        if (memBus.addr !== 32'h0) begin $display("[TB] FAIL reset_addr got %h want 0", memBus.addr); failCount++; end
        if (memBus.write_data !== 32'h0) begin $display("[TB] FAIL reset_wdata got %h want 0", memBus.write_data); failCount++; end
        if (memBus.sign_mask !== 4'b0100) begin $display("[TB] FAIL reset_sign_mask got %b want 0100", memBus.sign_mask); failCount++; end
        reset = 1'b0;
        @(negedge clk);
    endtask

    // Generic copy scenario: exact cycle timing when the memory never stalls, ordering otherwise.
    task automatic test_copy(input string name, input logic [31:0] src, input logic [31:0] dst,
                             input int n, input int stall, input int injCycle);
        int budget;
        int doneCycle;
        int doneCnt;
        int rdCnt;
        int wrCnt;
        int bothCnt;
        int errCnt;
        int memErr;
        logic expBit;
        stallMax = stall;
        for (int i = 0; i < MEM_WORDS; i++) refMem[i] = memArr[i];
        expData.delete();
        for (int k = 0; k < n; k++) begin
            expData.push_back(refMem[widx(src + 32'(4 * k))]);
            refMem[widx(dst + 32'(4 * k))] = refMem[widx(src + 32'(4 * k))];
        end
        budget = n * (6 + 2 * stall) + 6;
        applyStimulus(src, dst, LEN_W'(n));
        for (int c = 1; c <= budget; c++) begin
            @(negedge clk);
            sampleCycle(c);
            if (c == injCycle) begin
                start    = 1'b1;
                src_addr = $urandom() & 32'hFFFF_FFFC;
                dst_addr = $urandom() & 32'hFFFF_FFFC;
                len      = LEN_W'($urandom_range(1, 5));
            end else begin
                start = 1'b0;
            end
        end

        doneCycle = 0;
        doneCnt   = 0;
        rdCnt     = 0;
        wrCnt     = 0;
        bothCnt   = 0;
        errCnt    = 0;
        for (int c = 1; c <= budget; c++) begin
            if (doneA[c]) begin
                doneCnt++;
                if (doneCycle == 0) doneCycle = c;
            end
            if (rdA[c] && wrA[c]) bothCnt++;
            if (errA[c]) errCnt++;
            if (rdA[c]) begin
                if (rdCnt < n) begin
                    vecCount++;
                    if (addrA[c] !== src + 32'(4 * rdCnt)) begin
                        $display("[TB] FAIL %s rd_addr%0d got %h want %h", name, rdCnt, addrA[c], src + 32'(4 * rdCnt));
                        failCount++;
                    end
                end
                rdCnt++;
            end
            if (wrA[c]) begin
                if (wrCnt < n) begin
                    vecCount += 2;
                    if (addrA[c] !== dst + 32'(4 * wrCnt)) begin
                        $display("[TB] FAIL %s wr_addr%0d got %h want %h", name, wrCnt, addrA[c], dst + 32'(4 * wrCnt));
                        failCount++;
                    end
                    if (dataA[c] !== expData[wrCnt]) begin
                        $display("[TB] FAIL %s wr_data%0d got %h want %h", name, wrCnt, dataA[c], expData[wrCnt]);
                        failCount++;
                    end
                end
                wrCnt++;
            end
            if (stall == 0) begin
                vecCount += 3;
                expBit = (c <= 6 * n) && ((c - 1) % 6 == 0);
                if (rdA[c] !== expBit) begin
                    $display("[TB] FAIL %s memread_c%0d got %b want %b", name, c, rdA[c], expBit);
                    failCount++;
                end
                expBit = (c <= 6 * n) && (c >= 4) && ((c - 4) % 6 == 0);
                if (wrA[c] !== expBit) begin
                    $display("[TB] FAIL %s memwrite_c%0d got %b want %b", name, c, wrA[c], expBit);
                    failCount++;
                end
                expBit = (c == 6 * n + 1);
                if (doneA[c] !== expBit) begin
                    $display("[TB] FAIL %s done_c%0d got %b want %b", name, c, doneA[c], expBit);
                    failCount++;
                end
            end
        end

        for (int c = 1; c <= budget; c++) begin
            expBit = (c < doneCycle);
            vecCount++;
            if (busyA[c] !== expBit) begin
                $display("[TB] FAIL %s busy_c%0d got %b want %b", name, c, busyA[c], expBit);
                failCount++;
            end
        end

        vecCount += 5;
        if (doneCnt !== 1) begin $display("[TB] FAIL %s done_count got %0d want 1", name, doneCnt); failCount++; end
        if (rdCnt !== n) begin $display("[TB] FAIL %s read_count got %0d want %0d", name, rdCnt, n); failCount++; end
        if (wrCnt !== n) begin $display("[TB] FAIL %s write_count got %0d want %0d", name, wrCnt, n); failCount++; end
        if (bothCnt !== 0) begin $display("[TB] FAIL %s rd_wr_overlap got %0d want 0", name, bothCnt); failCount++; end
        if (errCnt !== 0) begin $display("[TB] FAIL %s err_count got %0d want 0", name, errCnt); failCount++; end
        if (n > 0) begin
            vecCount++;
            if (words_done !== LEN_W'(n)) begin
                $display("[TB] FAIL %s words_done got %0d want %0d", name, words_done, n);
                failCount++;
            end
        end
        memErr = 0;
        for (int i = 0; i < MEM_WORDS; i++) if (memArr[i] !== refMem[i]) memErr++;
        vecCount++;
        if (memErr !== 0) begin $display("[TB] FAIL %s memory_words_wrong got %0d want 0", name, memErr); failCount++; end
    endtask

    task automatic test_single_word();
        pokeWord(32'h1000, 32'hDEAD_BEEF);
        test_copy("single_word", 32'h1000, 32'h1100, 1, 0, 0);
        vecCount++;
        if (memArr[widx(32'h1100)] !== 32'hDEAD_BEEF) begin
            $display("[TB] FAIL single_word_dst got %h want deadbeef", memArr[widx(32'h1100)]);
            failCount++;
        end
    endtask

    task automatic test_multi_word();
        pokeWord(32'h1000, 32'h11);
        pokeWord(32'h1004, 32'h22);
        pokeWord(32'h1008, 32'h33);
        test_copy("three_words", 32'h1000, 32'h1200, 3, 0, 0);
        vecCount += 3;
        if (memArr[widx(32'h1200)] !== 32'h11) begin $display("[TB] FAIL three_words_w0 got %h want 11", memArr[widx(32'h1200)]); failCount++; end
        if (memArr[widx(32'h1204)] !== 32'h22) begin $display("[TB] FAIL three_words_w1 got %h want 22", memArr[widx(32'h1204)]); failCount++; end
        if (memArr[widx(32'h1208)] !== 32'h33) begin $display("[TB] FAIL three_words_w2 got %h want 33", memArr[widx(32'h1208)]); failCount++; end
    endtask

    task automatic test_zero_len();
        test_copy("zero_len", 32'h2000, 32'h3000, 0, 0, 0);
    endtask

    task automatic test_misaligned(input string name, input logic [31:0] src, input logic [31:0] dst);
        int memErr;
        logic expBit;
        stallMax = 0;
        for (int i = 0; i < MEM_WORDS; i++) refMem[i] = memArr[i];
        applyStimulus(src, dst, LEN_W'(4));
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            sampleCycle(c);
            start = 1'b0;
        end
        for (int c = 1; c <= 8; c++) begin
            expBit = (c == 1);
            vecCount += 2;
            if (errA[c] !== expBit) begin
                $display("[TB] FAIL %s err_c%0d got %b want %b", name, c, errA[c], expBit);
                failCount++;
            end
            if ((rdA[c] | wrA[c] | busyA[c] | doneA[c]) !== 1'b0) begin
                $display("[TB] FAIL %s activity_c%0d got rd%b wr%b busy%b done%b want all 0",
                         name, c, rdA[c], wrA[c], busyA[c], doneA[c]);
                failCount++;
            end
        end
        memErr = 0;
        for (int i = 0; i < MEM_WORDS; i++) if (memArr[i] !== refMem[i]) memErr++;
        vecCount++;
        if (memErr !== 0) begin $display("[TB] FAIL %s memory_words_wrong got %0d want 0", name, memErr); failCount++; end
    endtask

    task automatic test_start_while_busy();
        test_copy("start_in_wait", 32'h1000, 32'h1400, 2, 0, 5);
        test_copy("start_in_finish", 32'h1800, 32'h1900, 2, 0, 13);
    endtask

    task automatic test_reset_midcopy();
        logic [31:0] w0;
        logic [31:0] d1;
        stallMax = 0;
        w0 = memArr[widx(32'h1000)];
        d1 = memArr[widx(32'h1604)];
        applyStimulus(32'h1000, 32'h1600, LEN_W'(4));
        for (int c = 1; c <= 12; c++) begin
            @(negedge clk);
            start = 1'b0;
            if (c == 8) begin
                vecCount++;
                if (busy !== 1'b1) begin $display("[TB] FAIL reset_mid_busy_before got %b want 1", busy); failCount++; end
                reset = 1'b1;
            end
            if (c == 9) begin
                vecCount += 6;
                if (done !== 1'b0 || err !== 1'b0) begin $display("[TB] FAIL reset_mid_done_err got %b%b want 00", done, err); failCount++; end
                if (words_done !== '0) begin $display("[TB] FAIL reset_mid_words_done got %0d want 0", words_done); failCount++; end
                if (memBus.addr !== 32'h0) begin $display("[TB] FAIL reset_mid_addr got %h want 0", memBus.addr); failCount++; end
                if (memBus.write_data !== 32'h0) begin $display("[TB] FAIL reset_mid_wdata got %h want 0", memBus.write_data); failCount++; end
                if (memBus.memread !== 1'b0) begin $display("[TB] FAIL reset_mid_memread got %b want 0", memBus.memread); failCount++; end
                if (memBus.memwrite !== 1'b0) begin $display("[TB] FAIL reset_mid_memwrite got %b want 0", memBus.memwrite); failCount++; end
                reset = 1'b0;
            end
            if (c >= 9) begin
                vecCount++;
                if ((busy | memBus.memread | memBus.memwrite) !== 1'b0) begin
                    $display("[TB] FAIL reset_mid_idle_c%0d got busy%b rd%b wr%b want all 0",
                             c, busy, memBus.memread, memBus.memwrite);
                    failCount++;
                end
            end
        end
        vecCount += 2;
        if (memArr[widx(32'h1600)] !== w0) begin $display("[TB] FAIL reset_mid_word0 got %h want %h", memArr[widx(32'h1600)], w0); failCount++; end
        if (memArr[widx(32'h1604)] !== d1) begin $display("[TB] FAIL reset_mid_word1 got %h want %h", memArr[widx(32'h1604)], d1); failCount++; end
        test_copy("after_reset", 32'h1700, 32'h1780, 1, 0, 0);
    endtask

    task automatic test_overlap_wrap();
        logic [31:0] first;
        first = memArr[widx(32'h1000)];
        test_copy("overlap", 32'h1000, 32'h1004, 4, 0, 0);
        vecCount++;
        if (memArr[widx(32'h1010)] !== first) begin
            $display("[TB] FAIL overlap_propagate got %h want %h", memArr[widx(32'h1010)], first);
            failCount++;
        end
        test_copy("wrap", 32'hFFFF_FFF8, 32'h0000_0100, 4, 0, 0);
    endtask

    task automatic test_random_stall();
        logic [31:0] src;
        logic [31:0] dst;
        int n;
        int stall;
        for (int it = 0; it < 8; it++) begin
            src   = $urandom() & 32'hFFFF_FFFC;
            dst   = (it % 2 == 0) ? (src + 32'(4 * $urandom_range(0, 3))) : ($urandom() & 32'hFFFF_FFFC);
            n     = int'($urandom_range(1, 12));
            stall = int'($urandom_range(0, 3));
            test_copy($sformatf("random%0d", it), src, dst, n, stall, 0);
        end
    endtask

    initial begin
        reset     = 1'b1;
        start     = 1'b0;
        src_addr  = '0;
        dst_addr  = '0;
        len       = '0;
        fillReq   = 1'b0;
        pokeEn    = 1'b0;
        pokeAddr  = '0;
        pokeData  = '0;
        stallMax  = 0;
        vecCount  = 0;
        failCount = 0;
        test_reset();
        test_single_word();
        test_multi_word();
        test_zero_len();
        test_misaligned("misaligned_src", 32'h1002, 32'h1100);
        test_misaligned("misaligned_dst", 32'h1000, 32'h1101);
        test_start_while_busy();
        test_reset_midcopy();
        test_overlap_wrap();
        test_random_stall();
        $display("== %0d vectors applied, %0d miscompares ==", vecCount, failCount);
        $finish;
    end

endmodule
